btn_conditioner: RTL

- Input-side counterpart to the board's switch-to-LED output path.
- Takes the four raw, asynchronous push-buttons and produces synchronized, debounced levels, single-cycle press pulses and a priority-encoded press event with a valid/ready handshake.
- Also produces a latched one-hot "last pressed" vector that drives the LED display logic directly.

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/btn_conditioner.sv | 101 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

   localparam int unsigned N_BTN_DEF    = 4;
   // Short debounce window so simulations stay fast.
   localparam int unsigned DEBOUNCE_SIM = 4;

   typedef logic [N_BTN_DEF-1:0]         btn_vec_t;
   typedef logic [$clog2(N_BTN_DEF)-1:0] btn_idx_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each debounced press.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic clean,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          press_q, press_d;

   assign s     = sync_q[1];
   assign clean = stable_q;
   assign press = press_q;

   // Count consecutive cycles the synchronized level disagrees with the accepted level.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (s != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = s;
            // Pulse lands in the same cycle the debounced level first reads 1.
            press_d  = s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchronizer and debounce state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: per-button debounce, lowest-index press encoder,
// a 1-deep press event with valid/ready handshake and a sticky drop flag.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned N_BTN           = N_BTN_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_BTN-1:0]         btn,
   output logic [N_BTN-1:0]         btn_clean,
   output logic [N_BTN-1:0]         btn_press,
   output logic [N_BTN-1:0]         sel_onehot,
   output logic                     press_valid,
   output logic [$clog2(N_BTN)-1:0] press_idx,
   input  logic                     press_ready,
   output logic                     press_overflow,
   input  logic                     ovf_clear
);

   localparam int unsigned IW = $clog2(N_BTN);

   logic          cand_valid;
   logic [IW-1:0] cand_idx;
   logic          take, drop;

   logic             valid_q, valid_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [N_BTN-1:0] sel_q, sel_d;
   logic             ovf_q, ovf_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .rst  (rst),
         .btn  (btn[i]),
         .clean(btn_clean[i]),
         .press(btn_press[i])
      );
   end

   // Lowest set press bit wins; higher simultaneous presses are discarded.
   always_comb begin
      cand_valid = 1'b0;
      cand_idx   = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_press[i]) begin
            cand_valid = 1'b1;
            cand_idx   = IW'(i);
         end
      end
   end

   // Event register next state: consume, load (even on the consume edge) or drop.
   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      ovf_d   = ovf_q;
      take    = cand_valid && (!valid_q || press_ready);
      drop    = cand_valid && valid_q && !press_ready;
      if (valid_q && press_ready) begin
         valid_d = 1'b0;
      end
      if (take) begin
         valid_d = 1'b1;
         idx_d   = cand_idx;
         sel_d   = N_BTN'(1) << cand_idx;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clear) begin
         ovf_d = 1'b0;
      end
   end

   // Event and overflow state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         sel_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         ovf_q   <= ovf_d;
      end
   end

   assign press_valid    = valid_q;
   assign press_idx      = idx_q;
   assign sel_onehot     = sel_q;
   assign press_overflow = ovf_q;

endmodule
